mig: RTL and testbench

MIG -- requirements
Module: mig

---
 rtl/mig.sv | 245 ++++++++++++++++++++++++
 tb/tb_mig.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mig.sv
// Behavioural memory-interface model: command and write-data FIFOs feed an
// in-order burst-of-4 executor over a 64-bit word memory, with init sequencing.
module mig #(
  parameter int APPDATA_WIDTH = 128,
  parameter int MEM_WORDS     = 4096,
  parameter int INIT_CYCLES   = 16,
  parameter int AF_DEPTH      = 16,
  parameter int WDF_DEPTH     = 32,
  parameter int AFULL_MARGIN  = 4,
  parameter int RD_LATENCY    = 4
) (
  input  logic                       sys_clk_p,
  input  logic                       sys_clk_n,
  input  logic                       sys_rst_n,
  output logic                       clk0_tb,
  output logic                       rst0_tb,
  output logic                       phy_init_done,
  input  logic                       app_af_wren,
  input  logic [2:0]                 app_af_cmd,
  input  logic [30:0]                app_af_addr,
  output logic                       app_af_afull,
  input  logic                       app_wdf_wren,
  input  logic [APPDATA_WIDTH-1:0]   app_wdf_data,
  input  logic [APPDATA_WIDTH/8-1:0] app_wdf_mask_data,
  output logic                       app_wdf_afull,
  output logic                       rd_data_valid,
  output logic [APPDATA_WIDTH-1:0]   rd_data_fifo_out
);

  localparam int HALF   = APPDATA_WIDTH / 2;
  localparam int MASK_W = APPDATA_WIDTH / 8;
  localparam int HMASK  = MASK_W / 2;
  localparam int MW_AW  = $clog2(MEM_WORDS);
  localparam int AF_AW  = $clog2(AF_DEPTH);
  localparam int AFW    = AF_AW + 1;
  localparam int WD_AW  = $clog2(WDF_DEPTH);
  localparam int WDW    = WD_AW + 1;
  localparam int ICW    = $clog2(INIT_CYCLES) + 1;
  localparam int LCW    = $clog2(RD_LATENCY) + 1;
  localparam int WDF_EW = APPDATA_WIDTH + MASK_W;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  typedef enum logic [2:0] {
    IDLE, WRITE0, WRITE1, READ_WAIT, READ0, READ1
  } state_t;

  function automatic logic [HALF-1:0] merge_bytes(input logic [HALF-1:0]  old_w,
                                                  input logic [HALF-1:0]  new_w,
                                                  input logic [HMASK-1:0] keep);
    logic [HALF-1:0] res;
    for (int i = 0; i < HMASK; i++)
      res[i*8 +: 8] = keep[i] ? old_w[i*8 +: 8] : new_w[i*8 +: 8];
    return res;
  endfunction

  logic clk;
  assign clk     = sys_clk_p;
  assign clk0_tb = sys_clk_p;

  // Init sequencing
  logic [ICW-1:0] init_cnt;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rst0_tb       <= 1'b1;
      init_cnt      <= '0;
      phy_init_done <= 1'b0;
    end else begin
      rst0_tb <= 1'b0;
      if (!phy_init_done) begin
        if (init_cnt == ICW'(INIT_CYCLES - 1)) phy_init_done <= 1'b1;
        else                                    init_cnt      <= init_cnt + 1'b1;
      end
    end
  end

  // Command FIFO
  logic [33:0]      af_mem [AF_DEPTH];
  logic [AF_AW-1:0] af_wp, af_rp;
  logic [AFW-1:0]   af_cnt;
  logic             af_push, af_pop, af_empty;
  logic [2:0]       head_cmd;
  logic [30:0]      head_addr;

  assign af_push      = app_af_wren && (af_cnt != AFW'(AF_DEPTH));
  assign af_empty     = (af_cnt == '0);
  assign app_af_afull = (af_cnt >= AFW'(AF_DEPTH - AFULL_MARGIN));
  assign {head_cmd, head_addr} = af_mem[af_rp];

  always_ff @(posedge clk) begin
    if (af_push) af_mem[af_wp] <= {app_af_cmd, app_af_addr};
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      af_wp  <= '0;
      af_rp  <= '0;
      af_cnt <= '0;
    end else begin
      if (af_push) af_wp <= af_wp + 1'b1;
      if (af_pop)  af_rp <= af_rp + 1'b1;
      case ({af_push, af_pop})
        2'b10:   af_cnt <= af_cnt + 1'b1;
        2'b01:   af_cnt <= af_cnt - 1'b1;
        default: af_cnt <= af_cnt;
      endcase
    end
  end

  // Write-data FIFO
  logic [WDF_EW-1:0]        wdf_mem [WDF_DEPTH];
  logic [WD_AW-1:0]         wdf_wp, wdf_rp;
  logic [WDW-1:0]           wdf_cnt;
  logic                     wdf_push, wdf_pop;
  logic [APPDATA_WIDTH-1:0] wdf_data;
  logic [MASK_W-1:0]        wdf_mask;

  assign wdf_push      = app_wdf_wren && (wdf_cnt != WDW'(WDF_DEPTH));
  assign app_wdf_afull = (wdf_cnt >= WDW'(WDF_DEPTH - AFULL_MARGIN));
  assign {wdf_data, wdf_mask} = wdf_mem[wdf_rp];

  always_ff @(posedge clk) begin
    if (wdf_push) wdf_mem[wdf_wp] <= {app_wdf_data, app_wdf_mask_data};
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wdf_wp  <= '0;
      wdf_rp  <= '0;
      wdf_cnt <= '0;
    end else begin
      if (wdf_push) wdf_wp <= wdf_wp + 1'b1;
      if (wdf_pop)  wdf_rp <= wdf_rp + 1'b1;
      case ({wdf_push, wdf_pop})
        2'b10:   wdf_cnt <= wdf_cnt + 1'b1;
        2'b01:   wdf_cnt <= wdf_cnt - 1'b1;
        default: wdf_cnt <= wdf_cnt;
      endcase
    end
  end

  // Executor
  state_t           state, state_n;
  logic [MW_AW-3:0] burst, burst_n;
  logic [LCW-1:0]   lat_cnt, lat_cnt_n;
  logic             mem_we, rd_fire, hi_sel;
  logic [MW_AW-1:0] lo_idx, hi_idx;
  logic [HALF-1:0]  mem [MEM_WORDS];

  always_comb begin
    state_n   = state;
    burst_n   = burst;
    lat_cnt_n = lat_cnt;
    af_pop    = 1'b0;
    wdf_pop   = 1'b0;
    mem_we    = 1'b0;
    rd_fire   = 1'b0;
    case (state)
      IDLE: begin
        if (phy_init_done && !af_empty) begin
          case (head_cmd)
            CMD_WR: begin
              if (wdf_cnt >= WDW'(2)) begin
                af_pop  = 1'b1;
                burst_n = head_addr[MW_AW-1:2];
                state_n = WRITE0;
              end
            end
            CMD_RD: begin
              af_pop    = 1'b1;
              burst_n   = head_addr[MW_AW-1:2];
              lat_cnt_n = '0;
              state_n   = READ_WAIT;
            end
            default: af_pop = 1'b1;
          endcase
        end
      end
      WRITE0: begin
        wdf_pop = 1'b1;
        mem_we  = 1'b1;
        state_n = WRITE1;
      end
      WRITE1: begin
        wdf_pop = 1'b1;
        mem_we  = 1'b1;
        state_n = IDLE;
      end
      READ_WAIT: begin
        // Output is registered, so RD_LATENCY-1 wait states plus READ0 give RD_LATENCY.
        if (lat_cnt == LCW'(RD_LATENCY - 2)) state_n = READ0;
        else                                 lat_cnt_n = lat_cnt + 1'b1;
      end
      READ0: begin
        rd_fire = 1'b1;
        state_n = READ1;
      end
      READ1: begin
        rd_fire = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= IDLE;
      burst   <= '0;
      lat_cnt <= '0;
    end else begin
      state   <= state_n;
      burst   <= burst_n;
      lat_cnt <= lat_cnt_n;
    end
  end

  assign hi_sel = (state == WRITE1) || (state == READ1);
  assign lo_idx = {burst, hi_sel, 1'b0};
  assign hi_idx = {burst, hi_sel, 1'b1};

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[lo_idx] <= merge_bytes(mem[lo_idx], wdf_data[HALF-1:0], wdf_mask[HMASK-1:0]);
      mem[hi_idx] <= merge_bytes(mem[hi_idx], wdf_data[APPDATA_WIDTH-1:HALF],
                                 wdf_mask[MASK_W-1:HMASK]);
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rd_data_valid    <= 1'b0;
      rd_data_fifo_out <= '0;
    end else begin
      rd_data_valid <= rd_fire;
      if (rd_fire) rd_data_fifo_out <= {mem[hi_idx], mem[lo_idx]};
    end
  end

  logic unused_bits;
  assign unused_bits = &{1'b0, sys_clk_n, head_addr[30:MW_AW], head_addr[1:0]};

endmodule

// File: tb/tb_mig.sv
// Scoreboard bench for mig: stimulus pushes expected read words into a queue,
// a negedge monitor pops and compares whenever rd_data_valid is high.
module tb_mig;

  localparam int MEM_WORDS = 4096;

  logic         clk = 1'b0;
  logic         clk_n;
  logic         sys_rst_n;
  logic         clk0_tb, rst0_tb, phy_init_done;
  logic         app_af_wren;
  logic [2:0]   app_af_cmd;
  logic [30:0]  app_af_addr;
  logic         app_af_afull;
  logic         app_wdf_wren;
  logic [127:0] app_wdf_data;
  logic [15:0]  app_wdf_mask_data;
  logic         app_wdf_afull;
  logic         rd_data_valid;
  logic [127:0] rd_data_fifo_out;

  always #5 clk = ~clk;
  assign clk_n = ~clk;

  mig dut (
    .sys_clk_p(clk), .sys_clk_n(clk_n), .sys_rst_n(sys_rst_n),
    .clk0_tb(clk0_tb), .rst0_tb(rst0_tb), .phy_init_done(phy_init_done),
    .app_af_wren(app_af_wren), .app_af_cmd(app_af_cmd), .app_af_addr(app_af_addr),
    .app_af_afull(app_af_afull),
    .app_wdf_wren(app_wdf_wren), .app_wdf_data(app_wdf_data),
    .app_wdf_mask_data(app_wdf_mask_data), .app_wdf_afull(app_wdf_afull),
    .rd_data_valid(rd_data_valid), .rd_data_fifo_out(rd_data_fifo_out)
  );

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [127:0] exp_q[$];
  logic [127:0] mon_exp;
  logic [63:0]  model [int];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rd_data_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rd_valid: got %h expected no read data", rd_data_fifo_out);
      end else begin
        mon_exp = exp_q.pop_front();
        check("rd_data", rd_data_fifo_out, mon_exp);
      end
    end
  end

  task automatic push_cmd(input logic [2:0] c, input logic [30:0] a);
    app_af_cmd  = c;
    app_af_addr = a;
    app_af_wren = 1'b1;
    @(posedge clk); #1;
    app_af_wren = 1'b0;
  endtask

  task automatic push_wdf(input logic [127:0] d, input logic [15:0] m);
    app_wdf_data      = d;
    app_wdf_mask_data = m;
    app_wdf_wren      = 1'b1;
    @(posedge clk); #1;
    app_wdf_wren = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model_rd(input int idx);
    return model.exists(idx) ? model[idx] : 64'h0;
  endfunction

  task automatic model_wr(input logic [30:0] a, input logic [127:0] d0, input logic [127:0] d1,
                          input logic [15:0] m);
    int           base;
    logic [127:0] d;
    logic [63:0]  nw, ow;
    base = int'(a) & (MEM_WORDS - 1) & ~3;
    for (int w = 0; w < 4; w++) begin
      d  = (w < 2) ? d0 : d1;
      nw = (w % 2 == 0) ? d[63:0] : d[127:64];
      ow = model_rd(base + w);
      for (int b = 0; b < 8; b++)
        if (!m[(w % 2) * 8 + b]) ow[b*8 +: 8] = nw[b*8 +: 8];
      model[base + w] = ow;
    end
  endtask

  task automatic write_burst(input logic [30:0] a, input logic [127:0] d0, input logic [127:0] d1,
                             input logic [15:0] m);
    model_wr(a, d0, d1, m);
    push_cmd(3'b000, a);
    push_wdf(d0, m);
    push_wdf(d1, m);
  endtask

  task automatic read_burst(input logic [30:0] a);
    int base;
    base = int'(a) & (MEM_WORDS - 1) & ~3;
    exp_q.push_back({model_rd(base + 1), model_rd(base)});
    exp_q.push_back({model_rd(base + 3), model_rd(base + 2)});
    push_cmd(3'b001, a);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rst0_tb"}, rst0_tb, 1'b1);
    check({tag, "_init_done"}, phy_init_done, 1'b0);
    check({tag, "_rd_valid"}, rd_data_valid, 1'b0);
    check({tag, "_rd_data"}, rd_data_fifo_out, 128'h0);
    check({tag, "_af_afull"}, app_af_afull, 1'b0);
    check({tag, "_wdf_afull"}, app_wdf_afull, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    sys_rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs(tag);
    sys_rst_n = 1'b1;
  endtask

  function automatic logic [127:0] mkword(input int k, input int j);
    return {32'h1000_0000 + k, 32'h2000_0000 + j, 32'h3000_0000 + k, 32'h4000_0000 + j};
  endfunction

  int first_k, hi_cnt;

  initial begin
    sys_rst_n         = 1'b0;
    app_af_wren       = 1'b0;
    app_af_cmd        = '0;
    app_af_addr       = '0;
    app_wdf_wren      = 1'b0;
    app_wdf_data      = '0;
    app_wdf_mask_data = '0;

    // Reset state and init timing
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    sys_rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst0_tb_edge1", rst0_tb, 1'b0);
    check("init_done_edge1", phy_init_done, 1'b0);
    repeat (14) @(posedge clk);
    #1;
    check("init_done_edge15", phy_init_done, 1'b0);
    @(posedge clk); #1;
    check("init_done_edge16", phy_init_done, 1'b1);

    // Unmasked write then read of the same burst, with latency check
    write_burst(31'h10, 128'h1111_2222_3333_0001_4444_5555_6666_0000,
                        128'h7777_8888_9999_0003_AAAA_BBBB_CCCC_0002, 16'h0000);
    wait_cycles(10);
    exp_q.push_back(128'h1111_2222_3333_0001_4444_5555_6666_0000);
    exp_q.push_back(128'h7777_8888_9999_0003_AAAA_BBBB_CCCC_0002);
    push_cmd(3'b001, 31'h12);
    first_k = 0;
    hi_cnt  = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (rd_data_valid) begin
        hi_cnt++;
        if (first_k == 0) first_k = k;
      end
    end
    check("rd_first_valid_cycle", first_k, 5);
    check("rd_valid_cycles", hi_cnt, 2);

    // Masked write keeps upper 8 bytes of each word
    write_burst(31'h11, 128'hDEAD_BEEF_0000_1111_0123_4567_89AB_CDEF,
                        128'hFEED_FACE_2222_3333_FEDC_BA98_7654_3210, 16'hFF00);
    exp_q.push_back(128'h1111_2222_3333_0001_0123_4567_89AB_CDEF);
    exp_q.push_back(128'h7777_8888_9999_0003_FEDC_BA98_7654_3210);
    push_cmd(3'b001, 31'h10);

    // Interleaved byte mask
    write_burst(31'h20, 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF,
                        128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978, 16'h0000);
    write_burst(31'h20, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF,
                        128'h0, 16'h0F0F);
    exp_q.push_back(128'hFFFF_FFFF_4455_6677_FFFF_FFFF_CCDD_EEFF);
    exp_q.push_back(128'h0000_0000_89AB_CDEF_0000_0000_4B5A_6978);
    push_cmd(3'b001, 31'h23);

    // Address wraps modulo MEM_WORDS; undefined command has no effect
    write_burst(31'h1030, 128'hCAFE_0000_0000_0001_CAFE_0000_0000_0000,
                          128'hCAFE_0000_0000_0003_CAFE_0000_0000_0002, 16'h0000);
    push_cmd(3'b111, 31'h30);
    exp_q.push_back(128'hCAFE_0000_0000_0001_CAFE_0000_0000_0000);
    exp_q.push_back(128'hCAFE_0000_0000_0003_CAFE_0000_0000_0002);
    push_cmd(3'b001, 31'h31);
    wait_cycles(30);

    // Command FIFO afull with writes stalled on missing data
    for (int k = 0; k < 12; k++) begin
      model_wr(31'h100 + 31'(4 * k), mkword(k, 0), mkword(k, 1), 16'h0000);
      push_cmd(3'b000, 31'h100 + 31'(4 * k));
      if (k == 10) check("af_afull_at_11", app_af_afull, 1'b0);
      if (k == 11) check("af_afull_at_12", app_af_afull, 1'b1);
    end
    wait_cycles(5);
    check("af_afull_stalled", app_af_afull, 1'b1);
    push_wdf(mkword(0, 0), 16'h0000);
    wait_cycles(5);
    check("af_afull_one_wdf", app_af_afull, 1'b1);
    push_wdf(mkword(0, 1), 16'h0000);
    wait_cycles(5);
    check("af_afull_after_pop", app_af_afull, 1'b0);
    for (int k = 1; k < 12; k++) begin
      push_wdf(mkword(k, 0), 16'h0000);
      push_wdf(mkword(k, 1), 16'h0000);
    end
    wait_cycles(40);
    read_burst(31'h100);
    read_burst(31'h12C);
    wait_cycles(30);

    // Write-data FIFO afull, then flush by reset
    do_reset("rst2");
    for (int k = 0; k < 28; k++) begin
      push_wdf(mkword(100, k), 16'h0000);
      if (k == 26) check("wdf_afull_at_27", app_wdf_afull, 1'b0);
      if (k == 27) check("wdf_afull_at_28", app_wdf_afull, 1'b1);
    end
    do_reset("rst3");

    // Commands queued before phy_init_done
    write_burst(31'h200, 128'h5555_AAAA_0000_0001_5555_AAAA_0000_0000,
                         128'h5555_AAAA_0000_0003_5555_AAAA_0000_0002, 16'h0000);
    read_burst(31'h200);
    read_burst(31'h10);
    check("cmds_before_init_done", phy_init_done, 1'b0);
    wait_cycles(40);

    // Reset during READ_WAIT aborts the read; memory survives
    push_cmd(3'b001, 31'h200);
    @(posedge clk); #1;
    @(posedge clk); #1;
    sys_rst_n = 1'b0;
    repeat (4) @(negedge clk);
    check_reset_outputs("rst4");
    sys_rst_n = 1'b1;
    wait_cycles(10);
    check("no_valid_after_abort", rd_data_valid, 1'b0);
    wait_cycles(10);
    read_burst(31'h200);
    wait_cycles(20);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
